// File: rtl/btb_pkg.sv
// Shared op codes, controller states and a priority-encoder helper for the BTB array.
package btb_pkg;

  // Op codes on the shared entry bus; the entry slices decode the same values.
  localparam logic [2:0] OP_IDLE       = 3'b000;
  localparam logic [2:0] OP_CLEAR      = 3'b001;
  localparam logic [2:0] OP_LOOKUP     = 3'b100;
  localparam logic [2:0] OP_VERIFY_FT  = 3'b010;
  localparam logic [2:0] OP_VERIFY_TGT = 3'b011;
  localparam logic [2:0] OP_INSERT_FT  = 3'b110;
  localparam logic [2:0] OP_INSERT_TGT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_UPDATE = 2'd2,
    S_CLEAR  = 2'd3
  } state_e;

  // Index of the lowest set bit; 0 when no bit is set (callers qualify with |vec).
  function automatic logic [3:0] lowest_idx(input logic [15:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Victim selection: lowest empty entry first, otherwise a round-robin pointer.
module btb_victim_sel
  import btb_pkg::*;
#(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ENTRIES-1:0] i_empty,
  input  logic               i_adv,
  input  logic               i_clr,
  output logic [IDX_W-1:0]   o_victim,
  output logic               o_evict
);

  logic [IDX_W-1:0] r_rr;
  logic [15:0]      w_empty_ext;

  // Pick the lowest empty slot; fall back to the pointer only when every entry is valid.
  always_comb begin
    w_empty_ext = 16'(i_empty);
    o_evict     = ~|i_empty;
    o_victim    = o_evict ? r_rr : IDX_W'(lowest_idx(w_empty_ext));
  end

  // Pointer moves only on a real eviction; ENTRIES is a power of two so the add wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (i_clr) begin
      r_rr <= '0;
    end else if (i_adv) begin
      r_rr <= r_rr + 1'b1;
    end
  end

endmodule

// File: rtl/btb_ctrl.sv
// BTB array controller: fetch-time prediction plus verify/insert sequencing of resolutions.
module btb_ctrl
  import btb_pkg::*;
#(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           fetch_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [15:0]           pred_target,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [15:0]           res_pc,
  input  logic                  res_taken,
  input  logic [15:0]           res_target,
  input  logic                  clr_req,
  output logic                  clr_done,
  output logic [15:0]           btb_pc,
  output logic [2:0]            btb_op,
  output logic [ENTRIES-1:0]    btb_en,
  output logic [11:0]           btb_in_pc,
  output logic [15:0]           btb_in_target,
  input  logic [ENTRIES-1:0]    ent_hit,
  input  logic [ENTRIES-1:0]    ent_pred,
  input  logic [ENTRIES-1:0]    ent_empty,
  input  logic [16*ENTRIES-1:0] ent_target
);

  state_e               r_state, w_state_d;
  logic [15:0]          r_res_pc, r_res_target;
  logic                 r_res_taken;
  logic                 r_hit, r_evict;
  logic [IDX_W-1:0]     r_hit_idx, r_victim;
  logic [2:0]           r_op, w_op_d;
  logic [ENTRIES-1:0]   r_en, w_en_d;
  logic [11:0]          r_in_pc;
  logic [15:0]          r_in_target;
  logic                 r_clr_done, w_clr_done_d;
  logic                 w_accept, w_start_clr, w_any_hit, w_rr_adv, w_rr_clr, w_evict;
  logic [IDX_W-1:0]     w_hit_idx, w_victim;
  logic [ENTRIES-1:0]   w_one;

  btb_victim_sel #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_victim_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_empty  (ent_empty),
    .i_adv    (w_rr_adv),
    .i_clr    (w_rr_clr),
    .o_victim (w_victim),
    .o_evict  (w_evict)
  );

  // Handshake and prediction qualifiers; both forced low while reset is held.
  always_comb begin
    res_ready   = rst_n & (r_state == S_IDLE) & ~clr_req;
    pred_valid  = rst_n & (r_state == S_IDLE);
    w_accept    = res_valid & res_ready;
    // r_clr_done masks the cycle where the requester is still seeing its done pulse.
    w_start_clr = (r_state == S_IDLE) & clr_req & ~r_clr_done;
  end

  // Lowest-index hit drives the prediction and the shared lookup PC mux.
  always_comb begin
    w_any_hit   = |ent_hit;
    w_hit_idx   = IDX_W'(lowest_idx(16'(ent_hit)));
    pred_taken  = w_any_hit & ent_pred[w_hit_idx];
    pred_target = w_any_hit ? ent_target[{w_hit_idx, 4'b0000} +: 16] : '0;
    btb_pc      = ((r_state == S_CHECK) || (r_state == S_UPDATE)) ? r_res_pc : fetch_pc;
  end

  // Next state and the op to launch on the coming rising edge.
  always_comb begin
    w_state_d    = r_state;
    w_op_d       = OP_LOOKUP;
    w_en_d       = '0;
    w_clr_done_d = 1'b0;
    w_rr_adv     = 1'b0;
    w_rr_clr     = 1'b0;
    w_one        = ENTRIES'(1);
    unique case (r_state)
      S_IDLE: begin
        if (w_start_clr)   w_state_d = S_CLEAR;
        else if (w_accept) w_state_d = S_CHECK;
      end
      S_CHECK: w_state_d = S_UPDATE;
      S_UPDATE: begin
        w_state_d = S_IDLE;
        if (r_hit) begin
          w_en_d = w_one << r_hit_idx;
          w_op_d = r_res_taken ? OP_VERIFY_TGT : OP_VERIFY_FT;
        end else if (r_res_taken) begin
          w_en_d   = w_one << r_victim;
          w_op_d   = OP_INSERT_TGT;
          w_rr_adv = r_evict;
        end else begin
          w_op_d = OP_IDLE;
        end
      end
      S_CLEAR: begin
        w_state_d    = S_IDLE;
        w_op_d       = OP_CLEAR;
        w_en_d       = '1;
        w_clr_done_d = 1'b1;
        w_rr_clr     = 1'b1;
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  // State, accepted resolution and the hit/victim snapshot taken in S_CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_res_pc     <= '0;
      r_res_taken  <= 1'b0;
      r_res_target <= '0;
      r_hit        <= 1'b0;
      r_hit_idx    <= '0;
      r_victim     <= '0;
      r_evict      <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept && !w_start_clr) begin
        r_res_pc     <= res_pc;
        r_res_taken  <= res_taken;
        r_res_target <= res_target;
      end
      if (r_state == S_CHECK) begin
        r_hit     <= w_any_hit;
        r_hit_idx <= w_hit_idx;
        r_victim  <= w_victim;
        r_evict   <= w_evict;
      end
    end
  end

  // Entry-facing outputs launch on the rising edge so entries see them stable at the fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= OP_IDLE;
      r_en        <= '0;
      r_clr_done  <= 1'b0;
      r_in_pc     <= '0;
      r_in_target <= '0;
    end else begin
      r_op        <= w_op_d;
      r_en        <= w_en_d;
      r_clr_done  <= w_clr_done_d;
      r_in_pc     <= {1'b0, r_res_pc[15:5]};
      r_in_target <= r_res_target;
    end
  end

  assign btb_op        = r_op;
  assign btb_en        = r_en;
  assign clr_done      = r_clr_done;
  assign btb_in_pc     = r_in_pc;
  assign btb_in_target = r_in_target;

endmodule

// File: tb/tb_btb_ctrl.sv
// Self-checking bench for btb_ctrl: prediction table, resolution table with an op
// scoreboard, plus hand-written clear and reset-abort sequences.
module tb_btb_ctrl;
  import btb_pkg::*;

  localparam int unsigned ENTRIES = 4;
  localparam int unsigned IDX_W   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] fetch_pc;
  logic        pred_valid, pred_taken;
  logic [15:0] pred_target;
  logic        res_valid, res_ready, res_taken;
  logic [15:0] res_pc, res_target;
  logic        clr_req, clr_done;
  logic [15:0] btb_pc;
  logic [2:0]  btb_op;
  logic [3:0]  btb_en;
  logic [11:0] btb_in_pc;
  logic [15:0] btb_in_target;
  logic [3:0]  ent_hit, ent_pred, ent_empty;
  logic [63:0] ent_target;

  btb_ctrl #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_pc      (fetch_pc),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_pc        (res_pc),
    .res_taken     (res_taken),
    .res_target    (res_target),
    .clr_req       (clr_req),
    .clr_done      (clr_done),
    .btb_pc        (btb_pc),
    .btb_op        (btb_op),
    .btb_en        (btb_en),
    .btb_in_pc     (btb_in_pc),
    .btb_in_target (btb_in_target),
    .ent_hit       (ent_hit),
    .ent_pred      (ent_pred),
    .ent_empty     (ent_empty),
    .ent_target    (ent_target)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  en;
    logic [11:0] in_pc;
    logic [15:0] in_tgt;
    bit          chk_in;
    bit          clr;
    int          due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] pc;
    logic        tk;
    logic [15:0] tgt;
    logic [3:0]  hit;
    logic [3:0]  empty;
    logic [2:0]  eop;
    logic [3:0]  een;
  } res_vec_t;

  typedef struct {
    logic [3:0]  hit;
    logic [3:0]  pred;
    logic        etaken;
    logic [15:0] etarget;
  } pred_vec_t;

  res_vec_t  rv[10];
  pred_vec_t pv[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input res_vec_t v, input int due);
    exp_t e;
    e.op     = v.eop;
    e.en     = v.een;
    e.in_pc  = {1'b0, v.pc[15:5]};
    e.in_tgt = v.tgt;
    e.chk_in = (v.eop == OP_INSERT_TGT);
    e.clr    = 1'b0;
    e.due    = due;
    sb.push_back(e);
  endtask

  // Any non-LOOKUP op on the bus is a launched op: pop and compare, including its cycle.
  always @(negedge clk) begin
    if (mon_en && rst_n && btb_op !== OP_LOOKUP) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_op: got op %0h en %0h expected none", btb_op, btb_en);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("op", 32'(btb_op), 32'(e.op));
        chk("en", 32'(btb_en), 32'(e.en));
        chk("op_cycle", cyc, e.due);
        chk("clr_done_with_op", 32'(clr_done), 32'(e.clr));
        if (e.chk_in) begin
          chk("in_pc", 32'(btb_in_pc), 32'(e.in_pc));
          chk("in_target", 32'(btb_in_target), 32'(e.in_tgt));
        end
      end
    end
  end

  // Called just after a falling edge in S_IDLE; returns at the falling edge where the op shows.
  task automatic resolve(input res_vec_t v);
    res_valid = 1'b1;
    res_pc    = v.pc;
    res_taken = v.tk;
    res_target = v.tgt;
    ent_hit   = v.hit;
    ent_empty = v.empty;
    chk("res_ready_idle", 32'(res_ready), 32'd1);
    push(v, cyc + 3);
    @(posedge clk);
    @(negedge clk);
    res_valid = 1'b0;
    chk("pred_valid_check", 32'(pred_valid), 32'd0);
    chk("btb_pc_check", 32'(btb_pc), 32'(v.pc));
    @(negedge clk);
    chk("res_ready_update", 32'(res_ready), 32'd0);
    chk("pred_valid_update", 32'(pred_valid), 32'd0);
    @(negedge clk);
    chk("res_ready_back", 32'(res_ready), 32'd1);
  endtask

  initial begin
    res_vec_t v;
    exp_t     ce;

    // entry i target: A000, BEEF, C0DE, D00D
    pv[0] = '{4'b0000, 4'b0000, 1'b0, 16'h0000};
    pv[1] = '{4'b0010, 4'b0010, 1'b1, 16'hBEEF};
    pv[2] = '{4'b1000, 4'b0000, 1'b0, 16'hD00D};
    pv[3] = '{4'b1100, 4'b1000, 1'b0, 16'hC0DE};
    pv[4] = '{4'b0101, 4'b0001, 1'b1, 16'hA000};

    rv[0] = '{16'h1240, 1'b1, 16'h2000, 4'b0000, 4'b1111, OP_INSERT_TGT, 4'b0001};
    rv[1] = '{16'h3000, 1'b0, 16'h0000, 4'b0100, 4'b1010, OP_VERIFY_FT,  4'b0100};
    rv[2] = '{16'h5A60, 1'b1, 16'h6000, 4'b0110, 4'b1000, OP_VERIFY_TGT, 4'b0010};
    rv[3] = '{16'h7010, 1'b0, 16'h0000, 4'b0000, 4'b0000, OP_IDLE,       4'b0000};
    rv[4] = '{16'h8020, 1'b1, 16'h9000, 4'b0000, 4'b0100, OP_INSERT_TGT, 4'b0100};
    rv[5] = '{16'hA000, 1'b1, 16'hA100, 4'b0000, 4'b0000, OP_INSERT_TGT, 4'b0001};
    rv[6] = '{16'hA0E0, 1'b1, 16'hA200, 4'b0000, 4'b0000, OP_INSERT_TGT, 4'b0010};
    rv[7] = '{16'hB3C4, 1'b1, 16'hA300, 4'b0000, 4'b0000, OP_INSERT_TGT, 4'b0100};
    rv[8] = '{16'hFFFF, 1'b1, 16'hA400, 4'b0000, 4'b0000, OP_INSERT_TGT, 4'b1000};
    rv[9] = '{16'h0020, 1'b1, 16'hA500, 4'b0000, 4'b0000, OP_INSERT_TGT, 4'b0001};

    rst_n      = 1'b0;
    fetch_pc   = 16'h1234;
    res_valid  = 1'b0;
    res_pc     = '0;
    res_taken  = 1'b0;
    res_target = '0;
    clr_req    = 1'b0;
    ent_hit    = '0;
    ent_pred   = '0;
    ent_empty  = 4'b1111;
    ent_target = {16'hD00D, 16'hC0DE, 16'hBEEF, 16'hA000};

    #2;
    chk("rst_op", 32'(btb_op), 32'(OP_IDLE));
    chk("rst_en", 32'(btb_en), 32'd0);
    chk("rst_clr_done", 32'(clr_done), 32'd0);
    chk("rst_pred_valid", 32'(pred_valid), 32'd0);
    chk("rst_res_ready", 32'(res_ready), 32'd0);
    chk("rst_in_target", 32'(btb_in_target), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_pred_valid", 32'(pred_valid), 32'd1);
    chk("idle_pred_taken", 32'(pred_taken), 32'd0);
    chk("idle_pred_target", 32'(pred_target), 32'd0);
    chk("idle_op_lookup", 32'(btb_op), 32'(OP_LOOKUP));
    chk("idle_btb_pc", 32'(btb_pc), 32'h1234);
    chk("idle_en", 32'(btb_en), 32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      ent_hit  = pv[i].hit;
      ent_pred = pv[i].pred;
      #1;
      chk("pred_taken", 32'(pred_taken), 32'(pv[i].etaken));
      chk("pred_target", 32'(pred_target), 32'(pv[i].etarget));
    end
    ent_hit  = '0;
    ent_pred = '0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) resolve(rv[i]);

    // Clear raised in S_CHECK; the pending insert goes out first (rr is at 1 here).
    v = '{16'h4440, 1'b1, 16'h4444, 4'b0000, 4'b0000, OP_INSERT_TGT, 4'b0010};
    res_valid = 1'b1;
    res_pc = v.pc;
    res_taken = v.tk;
    res_target = v.tgt;
    ent_hit = v.hit;
    ent_empty = v.empty;
    push(v, cyc + 3);
    @(posedge clk);
    @(negedge clk);
    res_valid = 1'b0;
    clr_req = 1'b1;
    ce = '{OP_CLEAR, 4'b1111, 12'h0, 16'h0, 1'b0, 1'b1, cyc + 4};
    sb.push_back(ce);
    chk("clr_ready_check", 32'(res_ready), 32'd0);
    @(negedge clk);
    chk("clr_ready_update", 32'(res_ready), 32'd0);
    @(negedge clk);
    chk("clr_ready_held", 32'(res_ready), 32'd0);
    chk("clr_done_early", 32'(clr_done), 32'd0);
    @(negedge clk);
    chk("clr_ready_clear", 32'(res_ready), 32'd0);
    chk("clr_pred_valid", 32'(pred_valid), 32'd0);
    @(negedge clk);
    chk("clr_done_pulse", 32'(clr_done), 32'd1);
    clr_req = 1'b0;
    @(negedge clk);
    chk("clr_done_one_cycle", 32'(clr_done), 32'd0);
    chk("clr_no_repeat", 32'(btb_op), 32'(OP_LOOKUP));

    // rr was cleared: next eviction lands on entry 0.
    v = '{16'h6660, 1'b1, 16'h6666, 4'b0000, 4'b0000, OP_INSERT_TGT, 4'b0001};
    resolve(v);

    // Reset asserted in S_UPDATE aborts the pending insert (rr is at 1 here).
    res_valid = 1'b1;
    res_pc = 16'h7770;
    res_taken = 1'b1;
    res_target = 16'h7777;
    ent_hit = '0;
    ent_empty = '0;
    @(posedge clk);
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_op", 32'(btb_op), 32'(OP_IDLE));
    chk("abort_en", 32'(btb_en), 32'd0);
    chk("abort_res_ready", 32'(res_ready), 32'd0);
    chk("abort_pred_valid", 32'(pred_valid), 32'd0);
    @(negedge clk);
    chk("abort_op_held", 32'(btb_op), 32'(OP_IDLE));
    chk("abort_en_held", 32'(btb_en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_release_op", 32'(btb_op), 32'(OP_LOOKUP));
    chk("abort_release_en", 32'(btb_en), 32'd0);
    mon_en = 1'b1;

    // Reset also returned rr to 0.
    v = '{16'h8880, 1'b1, 16'h8888, 4'b0000, 4'b0000, OP_INSERT_TGT, 4'b0001};
    resolve(v);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
